// File: rtl/regfile_writeback.sv
// ---------------------------------------------------------------------------
// regfile_writeback
//
// Write-side master for the register file. Results arrive from the ALU and
// from the load unit; at most one of them is committed to the register file
// per cycle through a registered write port (d_address / datain / write_en).
// ALU results win the write port. A load that loses the port, or that arrives
// while older loads are still waiting, is held in a small in-order FIFO.
// pend_mask flags every register whose write has not yet been committed, so
// decode can detect hazards.
//
// Ports
//   clk, rst              clock and synchronous active-high reset
//   alu_valid/ready       ALU result handshake, with alu_rd / alu_data
//   ld_valid/ready        load result handshake, with ld_rd / ld_data
//   d_address, datain     registered register-file write index and data
//   write_en              registered register-file write strobe
//   pend_mask             bit r set: write to r queued or on the write port
//   fifo_count            load FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module regfile_writeback #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 3,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int NREG   = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] d_address,
    output logic [DATA_W-1:0] datain,
    output logic              write_en,
    output logic [NREG-1:0]   pend_mask,
    output logic [CNT_W-1:0]  fifo_count
);

    // Load FIFO storage. Every entry is visible to the hazard mask, so the
    // entries are plain registers rather than a RAM.
    logic [ADDR_W-1:0] fifo_rd_reg   [DEPTH];
    logic [DATA_W-1:0] fifo_data_reg [DEPTH];
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;

    // Registered write port
    logic [ADDR_W-1:0] d_address_reg, d_address_next;
    logic [DATA_W-1:0] datain_reg, datain_next;
    logic              write_en_reg, write_en_next;

    logic [DEPTH-1:0]  entry_valid;
    logic [NREG-1:0]   fifo_mask;
    logic [NREG-1:0]   port_mask;
    logic              alu_acc, ld_acc;
    logic              alu_wr, ld_wr;
    logic              fifo_empty;
    logic              push, pop;

    // An entry is live when its distance from the head (modulo DEPTH) is
    // below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_valid
        logic [PTR_W-1:0] offset;
        assign offset          = PTR_W'(gi) - head_reg;
        assign entry_valid[gi] = CNT_W'(offset) < count_reg;
    end

    // Registers with a write waiting in the FIFO. rd==0 is never enqueued,
    // so bit 0 stays clear.
    always_comb begin
        fifo_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                fifo_mask[fifo_rd_reg[i]] = 1'b1;
            end
        end
    end

    assign port_mask  = write_en_reg ? (NREG'(1) << d_address_reg) : '0;
    assign pend_mask  = fifo_mask | port_mask;
    assign fifo_empty = (count_reg == '0);

    // ld_ready depends only on occupancy (no alu_valid path, no credit for a
    // same-cycle pop). alu_ready holds the ALU back whenever an older load to
    // the same register is queued or being offered right now, which keeps
    // loads ahead of later ALU writes to the same register.
    assign ld_ready  = !rst && (count_reg < CNT_W'(DEPTH));
    assign alu_ready = !rst && !fifo_mask[alu_rd] &&
                       !(ld_valid && (ld_rd == alu_rd) && (ld_rd != '0));

    assign alu_acc = alu_valid && alu_ready;
    assign ld_acc  = ld_valid && ld_ready;
    // Results for register 0 complete their handshake but are discarded.
    assign alu_wr  = alu_acc && (alu_rd != '0);
    assign ld_wr   = ld_acc && (ld_rd != '0);

    // Write-port selection: ALU first, then FIFO head, then load bypass.
    always_comb begin
        push           = 1'b0;
        pop            = 1'b0;
        write_en_next  = 1'b0;
        d_address_next = d_address_reg;
        datain_next    = datain_reg;
        if (alu_wr) begin
            write_en_next  = 1'b1;
            d_address_next = alu_rd;
            datain_next    = alu_data;
            push           = ld_wr;
        end else if (!fifo_empty) begin
            pop            = 1'b1;
            write_en_next  = 1'b1;
            d_address_next = fifo_rd_reg[head_reg];
            datain_next    = fifo_data_reg[head_reg];
            push           = ld_wr;
        end else if (ld_wr) begin
            write_en_next  = 1'b1;
            d_address_next = ld_rd;
            datain_next    = ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            write_en_reg  <= 1'b0;
            d_address_reg <= '0;
            datain_reg    <= '0;
        end else begin
            write_en_reg  <= write_en_next;
            d_address_reg <= d_address_next;
            datain_reg    <= datain_next;
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry payload needs no reset: stale contents are masked by the count.
    // push is never set during reset because ld_ready is low.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_reg[tail_reg]   <= ld_rd;
            fifo_data_reg[tail_reg] <= ld_data;
        end
    end

    assign d_address  = d_address_reg;
    assign datain     = datain_reg;
    assign write_en   = write_en_reg;
    assign fifo_count = count_reg;

endmodule

// File: tb/tb_regfile_writeback.sv
// ---------------------------------------------------------------------------
// tb_regfile_writeback
//
// Directed bench for regfile_writeback: reset, ALU-only write, ALU/load
// collision, same-register ordering, FIFO full and drain, register 0 and
// mid-operation reset. A shadow register file captures writes on negedge.
// ---------------------------------------------------------------------------
module tb_regfile_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_valid;
    logic       alu_ready;
    logic [2:0] alu_rd;
    logic [7:0] alu_data;
    logic       ld_valid;
    logic       ld_ready;
    logic [2:0] ld_rd;
    logic [7:0] ld_data;
    logic [2:0] d_address;
    logic [7:0] datain;
    logic       write_en;
    logic [7:0] pend_mask;
    logic [2:0] fifo_count;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] shadow [8];

    always #5 clk = ~clk;

    regfile_writeback #(
        .DATA_W(8),
        .ADDR_W(3),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .d_address (d_address),
        .datain    (datain),
        .write_en  (write_en),
        .pend_mask (pend_mask),
        .fifo_count(fifo_count)
    );

    // Register file model: samples the write port on negedge.
    always @(negedge clk) begin
        if (write_en) begin
            shadow[d_address] <= datain;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) begin
            $display("%s: %0h", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [2:0] ard, input logic [7:0] adat,
                         input logic lv, input logic [2:0] lrd, input logic [7:0] ldat);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) shadow[i] = 8'h00;
        rst = 1'b1;
        drive(1'b1, 3'd3, 8'hEE, 1'b1, 3'd5, 8'hEE);

        // T1 reset
        check("t1_rst_alu_ready", alu_ready, 0);
        check("t1_rst_ld_ready", ld_ready, 0);
        tick();
        check("t1_rst_we_c1", write_en, 0);
        tick();
        check("t1_rst_we_c2", write_en, 0);
        rst = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        check("t1_ld_ready", ld_ready, 1);
        check("t1_alu_ready", alu_ready, 1);
        check("t1_count", fifo_count, 0);
        check("t1_pend", pend_mask, 0);
        check("t1_addr", d_address, 0);
        check("t1_data", datain, 0);

        // T2 ALU only
        drive(1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00);
        check("t2_alu_ready", alu_ready, 1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        check("t2_we", write_en, 1);
        check("t2_addr", d_address, 3);
        check("t2_data", datain, 8'h5A);
        check("t2_pend", pend_mask, 8'h08);
        tick();
        check("t2_we_off", write_en, 0);
        check("t2_addr_hold", d_address, 3);
        check("t2_data_hold", datain, 8'h5A);
        check("t2_pend_off", pend_mask, 0);

        // T3 collision
        drive(1'b1, 3'd2, 8'h11, 1'b1, 3'd5, 8'h22);
        check("t3_alu_ready", alu_ready, 1);
        check("t3_ld_ready", ld_ready, 1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        check("t3_n1_we", write_en, 1);
        check("t3_n1_addr", d_address, 2);
        check("t3_n1_data", datain, 8'h11);
        check("t3_n1_pend", pend_mask, 8'h24);
        check("t3_n1_count", fifo_count, 1);
        tick();
        check("t3_n2_we", write_en, 1);
        check("t3_n2_addr", d_address, 5);
        check("t3_n2_data", datain, 8'h22);
        check("t3_n2_count", fifo_count, 0);
        tick();
        check("t3_n3_pend", pend_mask, 0);
        check("t3_n3_we", write_en, 0);

        // T4 ordering on r4
        drive(1'b1, 3'd1, 8'h01, 1'b1, 3'd4, 8'h33);
        tick();
        drive(1'b1, 3'd1, 8'h02, 1'b0, 3'd0, 8'h00);
        check("t4_a_addr", d_address, 1);
        check("t4_a_count", fifo_count, 1);
        check("t4_a_pend", pend_mask, 8'h12);
        tick();
        check("t4_b_data", datain, 8'h02);
        check("t4_b_count", fifo_count, 1);
        drive(1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'h00);
        check("t4_alu_blocked", alu_ready, 0);
        tick();
        check("t4_pop_addr", d_address, 4);
        check("t4_pop_data", datain, 8'h33);
        check("t4_pop_count", fifo_count, 0);
        check("t4_alu_unblocked", alu_ready, 1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        check("t4_alu_we", write_en, 1);
        check("t4_alu_addr", d_address, 4);
        check("t4_alu_data", datain, 8'h44);
        tick();
        check("t4_final_r4", shadow[4], 8'h44);

        // T5 full and drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd1, 8'hA0, 1'b1, 3'(2 + i), 8'(8'h22 + i));
            check($sformatf("t5_fill%0d_ld_ready", i), ld_ready, 1);
            check($sformatf("t5_fill%0d_count", i), fifo_count, i);
            tick();
        end
        drive(1'b1, 3'd1, 8'hA0, 1'b1, 3'd6, 8'h26);
        check("t5_full_ld_ready", ld_ready, 0);
        check("t5_full_count", fifo_count, 4);
        check("t5_full_pend", pend_mask, 8'h3E);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h26);
        for (int j = 0; j < 5; j++) begin
            tick();
            if (j == 1) drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
            check($sformatf("t5_drain%0d_we", j), write_en, 1);
            check($sformatf("t5_drain%0d_addr", j), d_address, 2 + j);
            check($sformatf("t5_drain%0d_data", j), datain, 8'h22 + j);
            check($sformatf("t5_drain%0d_count", j), fifo_count, (j == 0) ? 3 : 4 - j);
        end
        tick();
        check("t5_idle_we", write_en, 0);
        check("t5_idle_pend", pend_mask, 0);

        // T6 register 0
        drive(1'b1, 3'd0, 8'h99, 1'b0, 3'd0, 8'h00);
        check("t6_r0_alu_ready", alu_ready, 1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 8'h98);
        check("t6_r0_alu_we", write_en, 0);
        check("t6_r0_ld_ready", ld_ready, 1);
        tick();
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        check("t6_r0_ld_we", write_en, 0);
        check("t6_r0_count", fifo_count, 0);

        // T6 reset with three queued loads
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'd1, 8'hB0, 1'b1, 3'(2 + i), 8'(8'h77 + i));
            tick();
        end
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00);
        check("t6_pre_count", fifo_count, 3);
        rst = 1'b1;
        #1;
        check("t6_rst_alu_ready", alu_ready, 0);
        check("t6_rst_ld_ready", ld_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("t6_post_we", write_en, 0);
        check("t6_post_count", fifo_count, 0);
        check("t6_post_pend", pend_mask, 0);
        check("t6_post_addr", d_address, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("t6_quiet%0d_we", k), write_en, 0);
        end
        check("t6_r2_kept", shadow[2], 8'h22);
        check("t6_r3_kept", shadow[3], 8'h23);
        check("t6_r4_kept", shadow[4], 8'h24);
        check("t6_r1_last", shadow[1], 8'hB0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
